qdrc_cal_seq: RTL and testbench
===============================

Name: qdrc_cal_seq

Overview:
Hardware calibration sequencer for the QDR soft-calibration PHY. It replaces software-driven per-bit tuning. On start it does the following:
- enables the PHY calibration pattern (rise=1, fall=0);
- for each data bit, sweeps the input delay taps and finds the widest valid eye;
- parks the delay at the eye centre;
- programs the rise/fall alignment from the sampled data value.
It sits beside the PHY, runs on the PHY divided clock, and drives the PHY's cal/train/align control inputs.

Parameters:
DATA_WIDTH, 36, number of data bits to calibrate (max 256)
TAP_COUNT, 64, delay taps per bit (0..TAP_COUNT-1)
TAP_WIDTH, 6, width of tap index; TAP_COUNT <= 2**TAP_WIDTH
MIN_WINDOW, 8, minimum acceptable eye width in taps
SETTLE_CYCLES, 16, wait cycles after a delay reset before the first sample
TIMEOUT, 1023, max cycles to wait for cal_rdy or data_sampled

Ports:
clk  in  1  divided PHY clock; same clock as PHY train logic
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin calibration
busy  out  1  calibration in progress
done  out  1  calibration passed; held until next start
fail  out  1  calibration failed; held until next start
fail_bit  out  8  bit index at which failure occurred
fail_code  out  2  0=none, 1=timeout, 2=eye too narrow, 3=bad data_value
cal_en  out  1  to PHY; enables calibration pattern
cal_rdy  in  1  from PHY; pattern running
bit_select  out  8  bit under calibration
dll_en  out  1  one-cycle delay-step strobe
dll_inc_dec_n  out  1  step direction; always 1 (increment)
dll_rst  out  1  one-cycle delay reset to tap 0
data_value  in  2  {fall,rise} sampled value of selected bit
data_sampled  in  1  pulse: fresh sample available
data_valid  in  1  sample stable (qualified by data_sampled)
align_en  out  1  alignment choice for selected bit (1=swap rise/fall)
align_strb  out  1  one-cycle strobe latching align_en for bit_select

Behaviour:
Reset (async, reset_n=0):
- state IDLE; all outputs 0; fail_code 0; window registers cleared.

Start and exit rules:
- start accepted only when busy=0.
- Accepting start clears done, fail, fail_code and fail_bit; the block then enters CAL_WAIT with cal_en=1 and busy=1.
- cal_en stays 1 from CAL_WAIT until DONE or FAIL is entered, then drops the same cycle.
- busy = 1 in all states except IDLE, DONE and FAIL.

State machine:
- CAL_WAIT: wait for cal_rdy=1, then bit=0 -> BIT_RST. Timeout after TIMEOUT cycles -> FAIL, code 1.
- BIT_RST: dll_rst=1 for one cycle; tap=0; cur_len=0, best_len=0 -> SETTLE.
- SETTLE: count SETTLE_CYCLES -> SAMPLE.
- SAMPLE: wait for data_sampled=1, then update the window:
  - If data_valid=1: when cur_len=0, cur_start=tap; then cur_len+1. If cur_len+1 > best_len (strictly greater), best_start=cur_start and best_len=cur_len+1.
  - If data_valid=0: cur_len=0.
  - Ties keep the first (lowest) window.
  - Next: if tap=TAP_COUNT-1 -> EVAL, else -> STEP.
  - Timeout -> FAIL, code 1.
- STEP: dll_en=1 for one cycle; tap+1 -> SAMPLE. Each step waits for a new data_sampled; a sample arriving in the same cycle as dll_en is ignored.
- EVAL: if best_len < MIN_WINDOW -> FAIL, code 2. Else center = best_start + (best_len>>1), floor; dll_rst pulse; tap=0 -> CENTER.
- CENTER: while tap != center: dll_en pulse, tap+1, one pulse per 2 cycles. At center -> CHECK.
- CHECK: wait for data_sampled (with timeout), then decode data_value:
  - 2'b01: align_en=0.
  - 2'b10: align_en=1.
  - otherwise: FAIL, code 3.
  - For valid values -> ALIGN.
- ALIGN: align_strb=1 for one cycle with align_en and bit_select stable -> NEXT.
- NEXT: if bit=DATA_WIDTH-1 -> DONE, else bit+1 -> BIT_RST.
- DONE: done=1. FAIL: fail=1, fail_bit=bit.
- DONE/FAIL hold until the next start.

Widths and signal stability:
- cur_len and best_len are TAP_WIDTH+1 bits; sums cannot wrap.
- bit_select is zero-extended bit; it is stable for the whole per-bit pass.
- align_en holds its last value until the next ALIGN.

Other boundary conditions:
- data_valid is ignored unless data_sampled=1.
- start pulses while busy are ignored.
- A window reaching tap TAP_COUNT-1 is counted (best updated in SAMPLE).
- An all-valid sweep gives best_start=0, best_len=TAP_COUNT, center=TAP_COUNT/2.
- reset_n asserted mid-calibration: immediately back to IDLE, cal_en=0, and no strobe is emitted.

Test Plan:
- DATA_WIDTH=2, TAP_COUNT=16, MIN_WINDOW=4; all bits valid at taps 3..10, data_value=01 -> 8 samples per bit window; center=7; 7 dll_en pulses after the centre dll_rst; align_strb with align_en=0 per bit; done=1, fail=0.
- Bit 1 valid at taps 1..3 and 8..13, data_value=10 -> best window 8..13; center=11; align_strb with align_en=1, bit_select=1; done=1.
- Bit 0 valid only at taps 5..6 (MIN_WINDOW=4) -> fail=1, fail_code=2, fail_bit=0, cal_en=0; no align_strb issued.
- cal_rdy held 0 -> after TIMEOUT cycles fail=1, fail_code=1, busy=0.
- data_value=11 at centre -> fail_code=3. Then a second start -> fail clears and a full pass runs.
- reset_n pulsed low during the STEP phase of bit 1 -> all outputs 0 in the same cycle; a new start afterwards begins again at bit 0.

Source files
------------

// File: rtl/qdrc_cal_seq_if.sv
// Handshake bundle between the QDR calibration sequencer, its host and the PHY.
// The master modport is the sequencer side; the slave modport is the host/PHY side.
interface qdrc_cal_seq_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] fail_bit;
  logic [1:0] fail_code;
  logic       cal_en;
  logic       cal_rdy;
  logic [7:0] bit_select;
  logic       dll_en;
  logic       dll_inc_dec_n;
  logic       dll_rst;
  logic [1:0] data_value;
  logic       data_sampled;
  logic       data_valid;
  logic       align_en;
  logic       align_strb;

  modport master (
    input  start, cal_rdy, data_value, data_sampled, data_valid,
    output busy, done, fail, fail_bit, fail_code, cal_en, bit_select,
           dll_en, dll_inc_dec_n, dll_rst, align_en, align_strb
  );

  modport slave (
    output start, cal_rdy, data_value, data_sampled, data_valid,
    input  busy, done, fail, fail_bit, fail_code, cal_en, bit_select,
           dll_en, dll_inc_dec_n, dll_rst, align_en, align_strb
  );
endinterface

// File: rtl/qdrc_cal_seq.sv
// QDR PHY calibration sequencer: per-bit delay-tap sweep, eye-centre parking
// and rise/fall alignment programming, run on the PHY divided clock.
module qdrc_cal_seq #(
  parameter int DATA_WIDTH    = 36,
  parameter int TAP_COUNT     = 64,
  parameter int TAP_WIDTH     = 6,
  parameter int MIN_WINDOW    = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT       = 1023
) (
  input  logic           clk,
  input  logic           reset_n,
  qdrc_cal_seq_if.master bus
);

  localparam int LEN_W   = TAP_WIDTH + 1;
  localparam int CNT_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(TAP_COUNT - 1);
  localparam logic [7:0]           BIT_LAST    = 8'(DATA_WIDTH - 1);
  localparam logic [LEN_W-1:0]     MIN_LEN     = LEN_W'(MIN_WINDOW);
  localparam logic [CNT_W-1:0]     TO_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_NARROW  = 2'd2;
  localparam logic [1:0] FC_BADVAL  = 2'd3;

  typedef enum logic [3:0] {
    IDLE, CAL_WAIT, BIT_RST, SETTLE, SAMPLE, STEP, EVAL,
    CENTER, CHECK, ALIGN, NEXT, DONE, FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             bit_q, bit_d;
  logic [TAP_WIDTH-1:0]   tap_q, tap_d;
  logic [TAP_WIDTH-1:0]   center_q, center_d;
  logic [TAP_WIDTH-1:0]   cur_start_q, cur_start_d;
  logic [TAP_WIDTH-1:0]   best_start_q, best_start_d;
  logic [LEN_W-1:0]       cur_len_q, cur_len_d;
  logic [LEN_W-1:0]       best_len_q, best_len_d;
  logic [LEN_W-1:0]       grow_len;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ph_q, ph_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic [1:0]             fail_code_q, fail_code_d;
  logic [7:0]             fail_bit_q, fail_bit_d;
  logic                   align_en_q, align_en_d;
  logic                   dll_en, dll_rst, align_strb;

  assign grow_len = cur_len_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      tap_q        <= '0;
      center_q     <= '0;
      cur_start_q  <= '0;
      best_start_q <= '0;
      cur_len_q    <= '0;
      best_len_q   <= '0;
      cnt_q        <= '0;
      ph_q         <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
      fail_bit_q   <= '0;
      align_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      tap_q        <= tap_d;
      center_q     <= center_d;
      cur_start_q  <= cur_start_d;
      best_start_q <= best_start_d;
      cur_len_q    <= cur_len_d;
      best_len_q   <= best_len_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
      fail_bit_q   <= fail_bit_d;
      align_en_q   <= align_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    tap_d        = tap_q;
    center_d     = center_q;
    cur_start_d  = cur_start_q;
    best_start_d = best_start_q;
    cur_len_d    = cur_len_q;
    best_len_d   = best_len_q;
    cnt_d        = cnt_q;
    ph_d         = ph_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_code_d  = fail_code_q;
    fail_bit_d   = fail_bit_q;
    align_en_d   = align_en_q;
    dll_en       = 1'b0;
    dll_rst      = 1'b0;
    align_strb   = 1'b0;

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (bus.start) begin
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FC_NONE;
          fail_bit_d  = '0;
          bit_d       = '0;
          state_d     = CAL_WAIT;
        end
      end
      CAL_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.cal_rdy) begin
          bit_d   = '0;
          state_d = BIT_RST;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAIL; fail_d = 1'b1; fail_code_d = FC_TIMEOUT; fail_bit_d = bit_q;
        end
      end
      BIT_RST: begin
        dll_rst      = 1'b1;
        tap_d        = '0;
        cur_len_d    = '0;
        best_len_d   = '0;
        cur_start_d  = '0;
        best_start_d = '0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.data_sampled) begin
          // Strictly-greater update keeps the lowest window on ties.
          if (bus.data_valid) begin
            if (cur_len_q == '0) cur_start_d = tap_q;
            cur_len_d = grow_len;
            if (grow_len > best_len_q) begin
              best_start_d = (cur_len_q == '0) ? tap_q : cur_start_q;
              best_len_d   = grow_len;
            end
          end else begin
            cur_len_d = '0;
          end
          state_d = (tap_q == TAP_LAST) ? EVAL : STEP;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAIL; fail_d = 1'b1; fail_code_d = FC_TIMEOUT; fail_bit_d = bit_q;
        end
      end
      STEP: begin
        dll_en  = 1'b1;
        tap_d   = tap_q + 1'b1;
        state_d = SAMPLE;
      end
      EVAL: begin
        if (best_len_q < MIN_LEN) begin
          state_d = FAIL; fail_d = 1'b1; fail_code_d = FC_NARROW; fail_bit_d = bit_q;
        end else begin
          center_d = TAP_WIDTH'({1'b0, best_start_q} + (best_len_q >> 1));
          dll_rst  = 1'b1;
          tap_d    = '0;
          ph_d     = 1'b0;
          state_d  = CENTER;
        end
      end
      CENTER: begin
        // Walk from tap 0 to the centre with one step every other cycle.
        if (tap_q == center_q) begin
          state_d = CHECK;
        end else if (!ph_q) begin
          dll_en = 1'b1;
          tap_d  = tap_q + 1'b1;
          ph_d   = 1'b1;
        end else begin
          ph_d = 1'b0;
        end
      end
      CHECK: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.data_sampled) begin
          case (bus.data_value)
            2'b01: begin align_en_d = 1'b0; state_d = ALIGN; end
            2'b10: begin align_en_d = 1'b1; state_d = ALIGN; end
            default: begin
              state_d = FAIL; fail_d = 1'b1; fail_code_d = FC_BADVAL; fail_bit_d = bit_q;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          state_d = FAIL; fail_d = 1'b1; fail_code_d = FC_TIMEOUT; fail_bit_d = bit_q;
        end
      end
      ALIGN: begin
        align_strb = 1'b1;
        state_d    = NEXT;
      end
      NEXT: begin
        if (bit_q == BIT_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          bit_d   = bit_q + 8'd1;
          state_d = BIT_RST;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every wait state measures from its own entry.
    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.busy          = !(state_q inside {IDLE, DONE, FAIL});
  assign bus.cal_en        = !(state_q inside {IDLE, DONE, FAIL});
  assign bus.done          = done_q;
  assign bus.fail          = fail_q;
  assign bus.fail_code     = fail_code_q;
  assign bus.fail_bit      = fail_bit_q;
  assign bus.bit_select    = bit_q;
  assign bus.dll_en        = dll_en;
  assign bus.dll_rst       = dll_rst;
  assign bus.dll_inc_dec_n = 1'b1;
  assign bus.align_en      = align_en_q;
  assign bus.align_strb    = align_strb;

endmodule

// File: tb/tb_qdrc_cal_seq.sv
// Bench for qdrc_cal_seq: a behavioural PHY delay line plus a scoreboard of
// expected alignment strobes (bit, align value, parked tap).
module tb_qdrc_cal_seq;
  localparam int DW = 2;
  localparam int TC = 16;
  localparam int TW = 4;
  localparam int MW = 4;
  localparam int SC = 4;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  qdrc_cal_seq_if bus();

  qdrc_cal_seq #(
    .DATA_WIDTH(DW), .TAP_COUNT(TC), .TAP_WIDTH(TW),
    .MIN_WINDOW(MW), .SETTLE_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  typedef struct {
    int   bitn;
    logic aen;
    int   ctr;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  logic [TC-1:0] eye [DW];
  logic [1:0]    val [DW];
  logic          rdy_en = 1'b1;
  int            tap_m = 0;
  int            cyc = 0;
  int            strb_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // PHY model: delay line tap, periodic samples, and strobe monitor.
  always @(negedge clk) begin
    int sel;
    exp_t e;
    sel = int'(bus.bit_select[0]);
    if (!reset_n)        tap_m = 0;
    else if (bus.dll_rst) tap_m = 0;
    else if (bus.dll_en)  tap_m = tap_m + 1;
    cyc = cyc + 1;
    bus.cal_rdy      = rdy_en;
    bus.data_sampled = (cyc % 3 == 0);
    bus.data_valid   = bus.data_sampled ? eye[sel][tap_m % TC] : ~eye[sel][tap_m % TC];
    bus.data_value   = val[sel];
    if (reset_n && bus.align_strb) begin
      strb_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexp_strb", {24'd0, bus.bit_select}, 32'hFFFF);
      end else begin
        e = sb_q.pop_front();
        chk("strb_bit", {24'd0, bus.bit_select}, e.bitn);
        chk("strb_aen", {31'd0, bus.align_en}, {31'd0, e.aen});
        chk("strb_tap", tap_m, e.ctr);
      end
    end
  end

  task automatic clr_eyes();
    for (int b = 0; b < DW; b++) begin
      eye[b] = '0;
      val[b] = 2'b01;
    end
  endtask

  task automatic set_win(input int b, input int lo, input int hi);
    for (int t = lo; t <= hi; t++) eye[b][t] = 1'b1;
  endtask

  task automatic push_exp(input int b, input logic aen, input int ctr);
    exp_t e;
    e.bitn = b; e.aen = aen; e.ctr = ctr;
    sb_q.push_back(e);
  endtask

  task automatic start_cal();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("go_busy", {31'd0, bus.busy}, 1);
    chk("go_calen", {31'd0, bus.cal_en}, 1);
    chk("go_clr", {20'd0, bus.done, bus.fail, bus.fail_code, bus.fail_bit}, 0);
  endtask

  task automatic wait_end(input int lim, input int poke_at);
    int n = 0;
    while (!(bus.done || bus.fail) && n < lim) begin
      @(negedge clk);
      n++;
      if (n == poke_at) bus.start = 1'b1;
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("finished", {31'd0, bus.done | bus.fail}, 1);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_status"}, {28'd0, bus.done, bus.fail, bus.busy, bus.cal_en}, 32'b1000);
    chk({tag, "_sb"}, sb_q.size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int s0;
    int n;
    bus.start = 1'b0;
    bus.cal_rdy = 1'b0;
    bus.data_sampled = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_value = 2'b00;
    clr_eyes();
    repeat (3) @(negedge clk);
    chk("rst_outs", {6'd0, bus.busy, bus.done, bus.fail, bus.cal_en, bus.dll_en, bus.dll_rst,
                     bus.align_en, bus.align_strb, bus.fail_code, bus.fail_bit, bus.bit_select}, 0);
    reset_n = 1'b1;

    // Both bits eye 3..10, value 01: centre 7, no swap.
    clr_eyes(); set_win(0, 3, 10); set_win(1, 3, 10);
    push_exp(0, 1'b0, 7); push_exp(1, 1'b0, 7);
    start_cal(); wait_end(3000, 0); chk_done("t1");

    // Bit 1 has two windows, widest 8..13, value 10; a start pulse while busy is ignored.
    clr_eyes(); set_win(0, 3, 10); set_win(1, 1, 3); set_win(1, 8, 13); val[1] = 2'b10;
    push_exp(0, 1'b0, 7); push_exp(1, 1'b1, 11);
    start_cal(); wait_end(3000, 40); chk_done("t2");
    chk("t2_aen_hold", {31'd0, bus.align_en}, 1);

    // All-valid sweep on bit 0 (centre 8); equal windows on bit 1 keep the lower one.
    clr_eyes(); set_win(0, 0, 15); set_win(1, 1, 4); set_win(1, 9, 12); val[1] = 2'b10;
    push_exp(0, 1'b0, 8); push_exp(1, 1'b1, 3);
    start_cal(); wait_end(3000, 0); chk_done("t3");

    // Widest window ends at the last tap.
    clr_eyes(); set_win(0, 2, 6); set_win(0, 10, 15); set_win(1, 0, 15);
    push_exp(0, 1'b0, 13); push_exp(1, 1'b0, 8);
    start_cal(); wait_end(3000, 0); chk_done("t4");

    // Eye too narrow on bit 0.
    clr_eyes(); set_win(0, 5, 6); set_win(1, 3, 10);
    s0 = strb_cnt;
    start_cal(); wait_end(3000, 0);
    chk("narrow_st", {27'd0, bus.done, bus.fail, bus.busy, bus.cal_en, 1'b0}, 32'b01000);
    chk("narrow_code", {30'd0, bus.fail_code}, 2);
    chk("narrow_bit", {24'd0, bus.fail_bit}, 0);
    chk("narrow_nostrb", strb_cnt - s0, 0);

    // cal_rdy never arrives.
    rdy_en = 1'b0; bus.cal_rdy = 1'b0;
    start_cal();
    repeat (TO - 2) @(negedge clk);
    chk("to_early", {30'd0, bus.busy, bus.fail}, 32'b10);
    repeat (2) @(negedge clk);
    chk("to_st", {29'd0, bus.fail, bus.busy, bus.cal_en}, 32'b100);
    chk("to_code", {30'd0, bus.fail_code}, 1);
    rdy_en = 1'b1;

    // Invalid rise/fall value at the centre, then a clean rerun.
    clr_eyes(); set_win(0, 3, 10); set_win(1, 3, 10); val[0] = 2'b11;
    s0 = strb_cnt;
    start_cal(); wait_end(3000, 0);
    chk("badval_fail", {31'd0, bus.fail}, 1);
    chk("badval_code", {30'd0, bus.fail_code}, 3);
    chk("badval_bit", {24'd0, bus.fail_bit}, 0);
    chk("badval_nostrb", strb_cnt - s0, 0);
    val[0] = 2'b01;
    push_exp(0, 1'b0, 7); push_exp(1, 1'b0, 7);
    start_cal(); wait_end(3000, 0); chk_done("t5");

    // Reset during the bit 1 sweep.
    clr_eyes(); set_win(0, 3, 10); set_win(1, 3, 10);
    push_exp(0, 1'b0, 7);
    start_cal();
    n = 0;
    while (!(bus.dll_en && bus.bit_select == 8'd1 && bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_step", {31'd0, bus.dll_en && bus.bit_select == 8'd1}, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_outs", {6'd0, bus.busy, bus.done, bus.fail, bus.cal_en, bus.dll_en, bus.dll_rst,
                        bus.align_en, bus.align_strb, bus.fail_code, bus.fail_bit, bus.bit_select}, 0);
    s0 = strb_cnt;
    repeat (3) @(negedge clk);
    chk("midrst_nostrb", strb_cnt - s0, 0);
    chk("midrst_sb", sb_q.size(), 0);
    #2 reset_n = 1'b1;
    push_exp(0, 1'b0, 7); push_exp(1, 1'b0, 7);
    start_cal(); wait_end(3000, 0); chk_done("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
